// File: rtl/display_scanner_if.sv
// Frame handoff between the per-digit segment decoders and the display scanner.
// The source presents a whole frame of segment codes and holds it until the
// scanner signals that its pending buffer is free.
interface display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [8*NUM_DIGITS-1:0] frame_data;   // digit i at [8i+7:8i], bit7 = segment A
    logic                    frame_valid;
    logic                    frame_ready;

    // Frame source (decoder side)
    modport master (
        output frame_data,
        output frame_valid,
        input  frame_ready
    );

    // Frame sink (scanner side)
    modport slave (
        input  frame_data,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment display scanner.
// Each digit slot is 8 sub-slots of PRESCALE clocks. Sub-slot 0 is always dark
// (anti-ghosting dead time) and sub-slots 1..bri_q are lit, giving 3-bit PWM.
// Frames are double-buffered: a new frame waits in the pending buffer and is
// promoted to the displayed buffer only at a frame boundary, so a scan never
// shows a mix of two frames.
module display_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_scanner_if.slave      frame_bus,
    input  logic [2:0]            brightness,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic [IDX_W-1:0]      scan_idx,
    output logic                  frame_start
);

    localparam int                    PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    // Scan counters
    logic [PRE_W-1:0]            r_pre_cnt;
    logic [2:0]                  r_sub_cnt;
    logic [IDX_W-1:0]            r_dig_cnt;

    // Frame buffers
    logic [8*NUM_DIGITS-1:0]     r_active_frame;
    logic [8*NUM_DIGITS-1:0]     r_pending_frame;
    logic                        r_pending_full;

    // Brightness latched per digit slot
    logic [2:0]                  r_bri_q;

    // Registered outputs
    logic [7:0]                  r_seg_out;
    logic [NUM_DIGITS-1:0]       r_dig_sel;
    logic [IDX_W-1:0]            r_scan_idx;

    logic                        w_pre_wrap;
    logic                        w_sub_wrap;
    logic                        w_boundary;
    logic                        w_slot_start;
    logic                        w_accept;
    logic                        w_lit;
    logic [7:0]                  w_seg_code;
    logic [NUM_DIGITS-1:0]       w_dig_onehot;

    assign w_pre_wrap   = (r_pre_cnt == PRE_W'(PRESCALE - 1));
    assign w_sub_wrap   = w_pre_wrap && (r_sub_cnt == 3'd7);
    assign w_boundary   = w_sub_wrap && (r_dig_cnt == IDX_W'(NUM_DIGITS - 1));
    assign w_slot_start = (r_pre_cnt == '0) && (r_sub_cnt == 3'd0);

    // The pending buffer is the only thing that can back-pressure the source.
    assign frame_bus.frame_ready = !r_pending_full;
    assign w_accept              = frame_bus.frame_valid && !r_pending_full;

    // Sub-slot 0 is the dead time; sub-slots 1..bri_q carry the PWM on-time.
    assign w_lit = (r_sub_cnt != 3'd0) && (r_sub_cnt <= r_bri_q);

    // Select the segment code and one-hot enable of the digit under scan
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        w_seg_code   = '0;
        w_dig_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_dig_cnt == IDX_W'(i)) begin
                w_seg_code      = r_active_frame[8*i +: 8];
                w_dig_onehot[i] = 1'b1;
            end
        end
    end

    // Prescaler, sub-slot and digit counters; digit index wraps, never saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
            r_sub_cnt <= 3'd0;
            r_dig_cnt <= '0;
        end else if (w_pre_wrap) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            r_pre_cnt <= '0;
            r_sub_cnt <= r_sub_cnt + 3'd1;
            if (w_sub_wrap) begin
                r_dig_cnt <= (r_dig_cnt == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_dig_cnt + IDX_W'(1);
            end
        end else begin
            r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        end
    end

    // Pending flag and displayed frame: accept on handshake, promote at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending_full <= 1'b0;
            r_active_frame <= '0;
        end else begin
            // Accept and promote are exclusive: accepting needs the buffer empty, promoting needs it full.
            if (w_accept) begin
                r_pending_full <= 1'b1;
            end else if (w_boundary && r_pending_full) begin
                r_pending_full <= 1'b0;
            end
            if (w_boundary && r_pending_full) begin
                r_active_frame <= r_pending_frame;
            end
        end
    end

    // Pending frame data register
    always_ff @(posedge clk) begin
        // NOTE: data-only storage is left unreset; r_pending_full qualifies it, so its power-up contents are never used.
        if (w_accept) begin
            r_pending_frame <= frame_bus.frame_data;
        end
    end

    // Latch brightness at the start of each digit slot so mid-slot changes wait for the next slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bri_q <= 3'd0;
        end else if (w_slot_start) begin
            r_bri_q <= brightness;
        end
    end

    // Output stage: one cycle behind the counters, polarity applied here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_out  <= SEG_OFF;
            r_dig_sel  <= DIG_OFF;
            r_scan_idx <= '0;
        end else begin
            r_seg_out  <= w_lit ? (w_seg_code ^ SEG_OFF) : SEG_OFF;
            r_dig_sel  <= w_lit ? (w_dig_onehot ^ DIG_OFF) : DIG_OFF;
            r_scan_idx <= r_dig_cnt;
        end
    end

    assign seg_out     = r_seg_out;
    assign dig_sel     = r_dig_sel;
    assign scan_idx    = r_scan_idx;
    assign frame_start = w_boundary;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with NUM_DIGITS=4, PRESCALE=2:
// a digit slot is 16 clocks and a frame is 64 clocks.
// cyc counts rising edges since reset release; at the falling edge after edge
// number c the counters hold state c and the registered outputs show state c-1.
module tb_display_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] brightness;
    logic [7:0] seg_out;
    logic [3:0] dig_sel;
    logic [1:0] scan_idx;
    logic       frame_start;

    int cyc;
    int errors = 0;
    int checks = 0;

    localparam logic [31:0] FRAME_1 = 32'h3F_60_DA_F2;
    localparam logic [31:0] FRAME_A = 32'h06_5B_4F_66;
    localparam logic [31:0] FRAME_B = 32'h6D_7D_07_7F;
    localparam logic [31:0] FRAME_C = 32'h6F_77_7C_39;
    localparam logic [31:0] FRAME_D = 32'h5E_79_71_3D;

    display_scanner_if #(.NUM_DIGITS(4)) frame_bus ();

    display_scanner #(
        .NUM_DIGITS     (4),
        .PRESCALE       (2),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_bus   (frame_bus),
        .brightness  (brightness),
        .seg_out     (seg_out),
        .dig_sel     (dig_sel),
        .scan_idx    (scan_idx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Expected behaviour for counter state s at a given latched brightness.
    function automatic bit lit_of(input int s, input int bri);
        int sub;
        sub = (s / 2) % 8;
        return (sub >= 1) && (sub <= bri);
    endfunction

    function automatic logic [3:0] exp_dsel(input int s, input int bri);
        logic [3:0] onehot;
        onehot = 4'b0001 << ((s / 16) % 4);
        return lit_of(s, bri) ? ~onehot : 4'hF;
    endfunction

    function automatic logic [7:0] exp_seg(input logic [31:0] f, input int s, input int bri);
        logic [7:0] code;
        code = f[8*((s / 16) % 4) +: 8];
        return lit_of(s, bri) ? code : 8'h00;
    endfunction

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cyc !== target) begin
            errors++;
            $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, target);
        end
    endtask

    task automatic test_reset;
        int first_fs;
        rst_n                 = 1'b0;
        brightness            = 3'd0;
        frame_bus.frame_valid = 1'b0;
        frame_bus.frame_data  = '0;
        repeat (3) @(negedge clk);
        checks++; if (seg_out !== 8'h00) begin errors++; $display("FAIL reset_seg: got %h need 00", seg_out); end
        checks++; if (dig_sel !== 4'hF) begin errors++; $display("FAIL reset_dsel: got %h need F", dig_sel); end
        checks++; if (frame_bus.frame_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b need 1", frame_bus.frame_ready); end
        checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d need 0", scan_idx); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fstart: got %b need 0", frame_start); end
        rst_n    = 1'b1;
        first_fs = -1;
        while (cyc < 64) begin
            @(negedge clk);
            if (frame_start === 1'b1 && first_fs < 0) first_fs = cyc;
            checks++;
            if (dig_sel !== 4'hF || seg_out !== 8'h00) begin
                errors++;
                $display("FAIL blank_first_frame cyc=%0d: dig_sel=%h seg_out=%h need F/00", cyc, dig_sel, seg_out);
            end
        end
        checks++;
        if (first_fs !== 63) begin errors++; $display("FAIL first_frame_start: at clk %0d need 63", first_fs); end
    endtask

    task automatic test_frame;
        int s;
        int n_dig0;
        wait_cyc(70);
        brightness            = 3'd7;
        frame_bus.frame_data  = FRAME_1;
        frame_bus.frame_valid = 1'b1;
        @(negedge clk);
        checks++; if (frame_bus.frame_ready !== 1'b0) begin errors++; $display("FAIL accept_ready: got %b need 0", frame_bus.frame_ready); end
        frame_bus.frame_valid = 1'b0;
        wait_cyc(127);
        checks++; if (frame_bus.frame_ready !== 1'b0) begin errors++; $display("FAIL pending_at_boundary: got %b need 0", frame_bus.frame_ready); end
        @(negedge clk);
        checks++; if (frame_bus.frame_ready !== 1'b1) begin errors++; $display("FAIL ready_after_promote: got %b need 1", frame_bus.frame_ready); end
        n_dig0 = 0;
        while (cyc < 192) begin
            @(negedge clk);
            s = cyc - 1;
            if (dig_sel === 4'hE) n_dig0++;
            checks++; if (dig_sel !== exp_dsel(s, 7)) begin errors++; $display("FAIL frame1_dsel cyc=%0d: got %h need %h", cyc, dig_sel, exp_dsel(s, 7)); end
            checks++; if (seg_out !== exp_seg(FRAME_1, s, 7)) begin errors++; $display("FAIL frame1_seg cyc=%0d: got %h need %h", cyc, seg_out, exp_seg(FRAME_1, s, 7)); end
            checks++; if (scan_idx !== 2'((s / 16) % 4)) begin errors++; $display("FAIL frame1_idx cyc=%0d: got %0d need %0d", cyc, scan_idx, (s / 16) % 4); end
            checks++; if (frame_start !== ((cyc % 64) == 63)) begin errors++; $display("FAIL frame1_fstart cyc=%0d: got %b", cyc, frame_start); end
        end
        checks++; if (n_dig0 !== 14) begin errors++; $display("FAIL digit0_on_time: %0d clks need 14", n_dig0); end
    endtask

    task automatic test_brightness;
        int s;
        int bri;
        int n_dig0;
        int n_dig2;
        brightness = 3'd0;
        while (cyc < 256) begin
            @(negedge clk);
            s = cyc - 1;
            checks++; if (dig_sel !== 4'hF) begin errors++; $display("FAIL bri0_dsel cyc=%0d: got %h need F", cyc, dig_sel); end
            checks++; if (seg_out !== 8'h00) begin errors++; $display("FAIL bri0_seg cyc=%0d: got %h need 00", cyc, seg_out); end
            checks++; if (scan_idx !== 2'((s / 16) % 4)) begin errors++; $display("FAIL bri0_idx cyc=%0d: got %0d need %0d", cyc, scan_idx, (s / 16) % 4); end
        end
        brightness = 3'd3;
        n_dig0 = 0;
        n_dig2 = 0;
        while (cyc < 320) begin
            @(negedge clk);
            s   = cyc - 1;
            bri = (((s / 16) % 4) < 2) ? 3 : 7;
            if (dig_sel === 4'hE) n_dig0++;
            if (dig_sel === 4'hB) n_dig2++;
            checks++; if (dig_sel !== exp_dsel(s, bri)) begin errors++; $display("FAIL bri3_dsel cyc=%0d: got %h need %h", cyc, dig_sel, exp_dsel(s, bri)); end
            checks++; if (seg_out !== exp_seg(FRAME_1, s, bri)) begin errors++; $display("FAIL bri3_seg cyc=%0d: got %h need %h", cyc, seg_out, exp_seg(FRAME_1, s, bri)); end
            // Mid-slot change during digit 1: must only take effect from digit 2.
            if (cyc == 278) brightness = 3'd7;
        end
        checks++; if (n_dig0 !== 6) begin errors++; $display("FAIL bri3_on_time: %0d clks need 6", n_dig0); end
        checks++; if (n_dig2 !== 14) begin errors++; $display("FAIL bri_change_next_slot: %0d clks need 14", n_dig2); end
    endtask

    task automatic test_back_to_back;
        int s;
        int n_ready;
        wait_cyc(330);
        frame_bus.frame_data  = FRAME_A;
        frame_bus.frame_valid = 1'b1;
        @(negedge clk);
        checks++; if (frame_bus.frame_ready !== 1'b0) begin errors++; $display("FAIL a_accept: ready=%b need 0", frame_bus.frame_ready); end
        frame_bus.frame_data = FRAME_B;
        n_ready = 0;
        while (cyc < 383) begin
            @(negedge clk);
            if (frame_bus.frame_ready !== 1'b0) n_ready++;
        end
        checks++; if (n_ready !== 0) begin errors++; $display("FAIL b_held_off: ready high %0d clks need 0", n_ready); end
        @(negedge clk);
        checks++; if (frame_bus.frame_ready !== 1'b1) begin errors++; $display("FAIL ready_after_a_promote: got %b need 1", frame_bus.frame_ready); end
        @(negedge clk);
        checks++; if (frame_bus.frame_ready !== 1'b0) begin errors++; $display("FAIL b_accept: ready=%b need 0", frame_bus.frame_ready); end
        frame_bus.frame_valid = 1'b0;
        while (cyc < 448) begin
            @(negedge clk);
            s = cyc - 1;
            checks++; if (dig_sel !== exp_dsel(s, 7)) begin errors++; $display("FAIL frameA_dsel cyc=%0d: got %h need %h", cyc, dig_sel, exp_dsel(s, 7)); end
            checks++; if (seg_out !== exp_seg(FRAME_A, s, 7)) begin errors++; $display("FAIL frameA_seg cyc=%0d: got %h need %h", cyc, seg_out, exp_seg(FRAME_A, s, 7)); end
        end
        while (cyc < 511) begin
            @(negedge clk);
            s = cyc - 1;
            checks++; if (seg_out !== exp_seg(FRAME_B, s, 7)) begin errors++; $display("FAIL frameB_seg cyc=%0d: got %h need %h", cyc, seg_out, exp_seg(FRAME_B, s, 7)); end
            checks++; if (frame_start !== ((cyc % 64) == 63)) begin errors++; $display("FAIL frameB_fstart cyc=%0d: got %b", cyc, frame_start); end
        end
        // Frame offered on the boundary cycle itself: accepted, but held pending a full frame.
        checks++; if (frame_bus.frame_ready !== 1'b1) begin errors++; $display("FAIL ready_at_boundary: got %b need 1", frame_bus.frame_ready); end
        frame_bus.frame_data  = FRAME_C;
        frame_bus.frame_valid = 1'b1;
        @(negedge clk);
        checks++; if (frame_bus.frame_ready !== 1'b0) begin errors++; $display("FAIL c_accept: ready=%b need 0", frame_bus.frame_ready); end
        frame_bus.frame_valid = 1'b0;
        wait_cyc(515);
        checks++; if (seg_out !== 8'h7F) begin errors++; $display("FAIL b_still_shown: seg=%h need 7F", seg_out); end
        checks++; if (dig_sel !== 4'hE) begin errors++; $display("FAIL b_still_dsel: dig_sel=%h need E", dig_sel); end
        wait_cyc(575);
        checks++; if (frame_bus.frame_ready !== 1'b0) begin errors++; $display("FAIL c_pending: ready=%b need 0", frame_bus.frame_ready); end
        @(negedge clk);
        checks++; if (frame_bus.frame_ready !== 1'b1) begin errors++; $display("FAIL c_promoted: ready=%b need 1", frame_bus.frame_ready); end
        wait_cyc(579);
        checks++; if (seg_out !== 8'h39) begin errors++; $display("FAIL c_shown: seg=%h need 39", seg_out); end
    endtask

    task automatic test_reset_midscan;
        int s;
        wait_cyc(617);
        checks++; if (dig_sel !== 4'hB) begin errors++; $display("FAIL pre_reset_dsel: got %h need B", dig_sel); end
        checks++; if (seg_out !== 8'h77) begin errors++; $display("FAIL pre_reset_seg: got %h need 77", seg_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (seg_out !== 8'h00) begin errors++; $display("FAIL async_seg: got %h need 00", seg_out); end
        checks++; if (dig_sel !== 4'hF) begin errors++; $display("FAIL async_dsel: got %h need F", dig_sel); end
        checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL async_idx: got %0d need 0", scan_idx); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL async_fstart: got %b need 0", frame_start); end
        frame_bus.frame_data  = FRAME_D;
        frame_bus.frame_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (frame_bus.frame_ready !== 1'b1) begin errors++; $display("FAIL held_reset_ready: got %b need 1", frame_bus.frame_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (frame_bus.frame_ready !== 1'b0) begin errors++; $display("FAIL first_clk_accept: ready=%b need 0", frame_bus.frame_ready); end
        checks++; if (scan_idx !== 2'd0 || dig_sel !== 4'hF) begin errors++; $display("FAIL restart_digit0: idx=%0d dig_sel=%h need 0/F", scan_idx, dig_sel); end
        frame_bus.frame_valid = 1'b0;
        while (cyc < 64) begin
            @(negedge clk);
            s = cyc - 1;
            checks++; if (seg_out !== 8'h00) begin errors++; $display("FAIL blank_after_reset cyc=%0d: seg=%h need 00", cyc, seg_out); end
            checks++; if (dig_sel !== exp_dsel(s, 7)) begin errors++; $display("FAIL restart_dsel cyc=%0d: got %h need %h", cyc, dig_sel, exp_dsel(s, 7)); end
            checks++; if (frame_start !== (cyc == 63)) begin errors++; $display("FAIL restart_fstart cyc=%0d: got %b", cyc, frame_start); end
        end
        while (cyc < 128) begin
            @(negedge clk);
            s = cyc - 1;
            checks++; if (seg_out !== exp_seg(FRAME_D, s, 7)) begin errors++; $display("FAIL frameD_seg cyc=%0d: got %h need %h", cyc, seg_out, exp_seg(FRAME_D, s, 7)); end
            checks++; if (scan_idx !== 2'((s / 16) % 4)) begin errors++; $display("FAIL frameD_idx cyc=%0d: got %0d need %0d", cyc, scan_idx, (s / 16) % 4); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_brightness();
        test_back_to_back();
        test_reset_midscan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
